iob_nco_mc: RTL and testbench
=============================

# iob_nco_mc

Multi-channel numerically controlled oscillator. It generates N_CH independent output clocks, each with its own fractional period (INT_W.FRAC_W fixed point), from one system clock. Each channel has:
- a selectable output waveform: 50 % duty or single-cycle pulse;
- glitch-free period updates through a shadow register;
- a common sync strobe that phase-aligns all channels.

It sits behind the peripheral CSR block as the next-generation replacement for the single-channel NCO.

## Interface

Parameters
- N_CH, 4: number of channels (≥1).
- INT_W, 16: integer bits of period.
- FRAC_W, 16: fractional bits of period.
- CH_W, derived: channel-select width, max(1, $clog2(N_CH)).

Ports
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_i  in  1  reset; synchronous, active-high; overrides cke_i.
- cke_i  in  1  clock enable; 0 freezes all state.
- cfg_wen_i  in  1  config write strobe, one cycle per write.
- cfg_ch_i  in  CH_W  target channel; writes with cfg_ch_i ≥ N_CH are ignored.
- cfg_period_i  in  INT_W+FRAC_W  period {int, frac} in clk_i cycles.
- cfg_mode_i  in  1  0 = 50 % duty, 1 = pulse.
- en_i  in  N_CH  per-channel enable, level.
- sync_i  in  1  restart all enabled channels.
- clk_o  out  N_CH  generated clocks, registered.
- tick_o  out  N_CH  one-cycle strobe at the first cycle of each output period, registered.
- cfg_pend_o  out  N_CH  shadow write waiting for its period boundary.

## Operation

Per-channel registers:
- period P = {P_int, P_frac} and mode M;
- shadow S and shadow mode;
- pend flag;
- error accumulator e (FRAC_W bits);
- length register len (INT_W+1 bits);
- counter cnt (INT_W+1 bits);
- state IDLE or RUN.

Arithmetic, evaluated at each period start:
- {carry, e_next} = e + P_frac, FRAC_W+1 bits.
- len = P_int + carry.
- e ← e_next.
- The long-run average period equals P exactly, and no overflow is possible at P = all ones.

Validity: a period is valid if P_int ≥ 2.

State transitions:
- IDLE → RUN: when en_i = 1 and P is valid. The first RUN cycle has cnt = 0, e starts at 0, and len is computed as above.
- RUN: cnt increments each cycle. A boundary occurs when cnt = len−1. At a boundary:
  - cnt ← 0;
  - if pend, then P, M ← shadow, e ← 0, pend ← 0;
  - len and e are recomputed from the (new) P.
- RUN → IDLE: when en_i = 0, or when a boundary loads an invalid P. On entering IDLE, cnt and e are cleared, clk_o = 0 and tick_o = 0.

Output in RUN:
- clk_o = (M ? cnt == 0 : cnt < len>>1). With odd len, the high phase is the shorter phase.
- tick_o = (cnt == 0).

Configuration writes:
- Write to an IDLE channel: P and M load directly and pend stays 0.
- Write to a RUN channel: goes to the shadow and sets pend. A later write before the boundary overwrites the shadow. pend is visible on cfg_pend_o.

sync_i:
- Every channel that is in RUN or has en_i = 1 restarts next cycle as a fresh period start: cnt = 0, e = 0, pending shadow applied first.
- Channels with an invalid P remain IDLE.

## Timing

- Reset: every output is 0. P, shadow, e, cnt and len are 0, pend is 0, and all channels are IDLE.
- en_i rising in cycle t: clk_o and tick_o are high in cycle t+1 (mode 0, len ≥ 2).
- en_i falling in cycle t: clk_o = 0 from cycle t+1. A pending shadow is applied on the next enable.
- Write in cycle t to an IDLE channel: the new P is usable by an enable sampled in cycle t+1.
- Write in the same cycle as a boundary: that boundary uses the old shadow state, and the new value goes to the shadow (pend = 1). cfg_pend_o rises in cycle t+1.
- sync_i together with a write to the same channel: the sync restart uses the prior state, and the write lands in the shadow.
- sync_i together with en_i falling: disable wins.
- Priority order: rst_i, then cke_i, then en_i = 0, then sync_i, then boundary.
- While cke_i = 0, outputs hold their last value.

## Test plan

- P = 2.5 (int 2, frac 0x8000), mode 0, enable ch0 -> period lengths alternate 2, 3, 2, 3; 400 ticks in 1000 cycles; clk_o high 1 cycle per period.
- ch1 running P = 10; write P = 4 when cnt = 3 -> cfg_pend_o[1] high until the boundary; current period completes 10 cycles; then 4-cycle periods, clk_o high 2 cycles each.
- ch0 P = 6 and ch2 P = 9, out of phase; pulse sync_i -> both tick_o high in the next cycle; subsequent ticks at 6 and 9 cycle spacing from that point.
- P = 5, mode 1 -> clk_o is a 1-cycle pulse every 5 cycles, coincident with tick_o; mode 0 -> high 2 cycles, low 3.
- P_int = 1 with en_i high -> clk_o and tick_o stay 0 indefinitely; then write P = 3 -> running from the cycle after the write plus one.
- Assert rst_i mid-period on all channels running -> the next cycle has all outputs 0 and all channels IDLE; re-enable without rewriting P -> P = 0 is invalid, so no output.

Source files
------------

// File: rtl/iob_nco_mc.sv
// rtl/iob_nco_mc.sv - multi-channel fractional-period NCO with shadowed period updates
module iob_nco_mc #(
    parameter int N_CH   = 4,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 16,
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cke_i,
    input  logic                    cfg_wen_i,
    input  logic [CH_W-1:0]         cfg_ch_i,
    input  logic [INT_W+FRAC_W-1:0] cfg_period_i,
    input  logic                    cfg_mode_i,
    input  logic [N_CH-1:0]         en_i,
    input  logic                    sync_i,
    output logic [N_CH-1:0]         clk_o,
    output logic [N_CH-1:0]         tick_o,
    output logic [N_CH-1:0]         cfg_pend_o
);
    localparam int PW = INT_W + FRAC_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q  [N_CH];
    state_t            state_d  [N_CH];
    logic [PW-1:0]     period_q [N_CH];
    logic [PW-1:0]     period_d [N_CH];
    logic [PW-1:0]     shadow_q [N_CH];
    logic [PW-1:0]     shadow_d [N_CH];
    logic              mode_q   [N_CH];
    logic              mode_d   [N_CH];
    logic              smode_q  [N_CH];
    logic              smode_d  [N_CH];
    logic              pend_q   [N_CH];
    logic              pend_d   [N_CH];
    logic [FRAC_W-1:0] err_q    [N_CH];
    logic [FRAC_W-1:0] err_d    [N_CH];
    logic [INT_W:0]    len_q    [N_CH];
    logic [INT_W:0]    len_d    [N_CH];
    logic [INT_W:0]    cnt_q    [N_CH];
    logic [INT_W:0]    cnt_d    [N_CH];
    logic [N_CH-1:0]   clk_q, clk_d, tick_q, tick_d;

    logic              reload, keep_err, wr;
    logic [PW-1:0]     p_eff;
    logic [FRAC_W:0]   sum;

    always_comb begin
        clk_d    = '0;
        tick_d   = '0;
        reload   = 1'b0;
        keep_err = 1'b0;
        wr       = 1'b0;
        p_eff    = '0;
        sum      = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]  = state_q[i];
            period_d[i] = period_q[i];
            shadow_d[i] = shadow_q[i];
            mode_d[i]   = mode_q[i];
            smode_d[i]  = smode_q[i];
            pend_d[i]   = pend_q[i];
            err_d[i]    = err_q[i];
            len_d[i]    = len_q[i];
            cnt_d[i]    = cnt_q[i];
            reload      = 1'b0;
            keep_err    = 1'b0;
            p_eff       = '0;
            sum         = '0;
            wr          = cfg_wen_i && (cfg_ch_i == CH_W'(i));

            if (!en_i[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
                err_d[i]   = '0;
            end else if (sync_i || state_q[i] == IDLE) begin
                reload = 1'b1;
            end else if (cnt_q[i] == len_q[i] - 1'b1) begin
                reload   = 1'b1;
                keep_err = !pend_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end

            // Period start: apply any pending shadow, then derive this period's length
            if (reload) begin
                p_eff       = pend_q[i] ? shadow_q[i] : period_q[i];
                period_d[i] = p_eff;
                mode_d[i]   = pend_q[i] ? smode_q[i] : mode_q[i];
                pend_d[i]   = 1'b0;
                cnt_d[i]    = '0;
                sum = {1'b0, (keep_err ? err_q[i] : {FRAC_W{1'b0}})} + {1'b0, p_eff[FRAC_W-1:0]};
                if (p_eff[PW-1:FRAC_W] >= INT_W'(2)) begin
                    state_d[i] = RUN;
                    len_d[i]   = {1'b0, p_eff[PW-1:FRAC_W]} + {{INT_W{1'b0}}, sum[FRAC_W]};
                    err_d[i]   = sum[FRAC_W-1:0];
                end else begin
                    state_d[i] = IDLE;
                    err_d[i]   = '0;
                end
            end

            clk_d[i]  = (state_d[i] == RUN) &&
                        (mode_d[i] ? (cnt_d[i] == '0) : (cnt_d[i] < (len_d[i] >> 1)));
            tick_d[i] = (state_d[i] == RUN) && (cnt_d[i] == '0);

            // A channel that will be running next cycle only ever takes new periods via the shadow
            if (wr) begin
                if (state_d[i] == IDLE) begin
                    period_d[i] = cfg_period_i;
                    mode_d[i]   = cfg_mode_i;
                end else begin
                    shadow_d[i] = cfg_period_i;
                    smode_d[i]  = cfg_mode_i;
                    pend_d[i]   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= IDLE;
                period_q[i] <= '0;
                shadow_q[i] <= '0;
                mode_q[i]   <= 1'b0;
                smode_q[i]  <= 1'b0;
                pend_q[i]   <= 1'b0;
                err_q[i]    <= '0;
                len_q[i]    <= '0;
                cnt_q[i]    <= '0;
            end
            clk_q  <= '0;
            tick_q <= '0;
        end else if (cke_i) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= state_d[i];
                period_q[i] <= period_d[i];
                shadow_q[i] <= shadow_d[i];
                mode_q[i]   <= mode_d[i];
                smode_q[i]  <= smode_d[i];
                pend_q[i]   <= pend_d[i];
                err_q[i]    <= err_d[i];
                len_q[i]    <= len_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;

    always_comb begin
        cfg_pend_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            cfg_pend_o[i] = pend_q[i];
        end
    end
endmodule

// File: tb/tb_iob_nco_mc.sv
// tb/tb_iob_nco_mc.sv - self-checking bench for iob_nco_mc against a closed-form period model
module tb_iob_nco_mc;
    localparam int N_CH   = 3;
    localparam int INT_W  = 16;
    localparam int FRAC_W = 16;
    localparam int PW     = INT_W + FRAC_W;
    localparam int CH_W   = 2;

    logic                  clk_i = 1'b0;
    logic                  rst_i, cke_i, cfg_wen_i, cfg_mode_i, sync_i;
    logic [CH_W-1:0]       cfg_ch_i;
    logic [PW-1:0]         cfg_period_i;
    logic [N_CH-1:0]       en_i, clk_o, tick_o, cfg_pend_o;

    iob_nco_mc #(.N_CH(N_CH), .INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cke_i(cke_i), .cfg_wen_i(cfg_wen_i),
        .cfg_ch_i(cfg_ch_i), .cfg_period_i(cfg_period_i), .cfg_mode_i(cfg_mode_i),
        .en_i(en_i), .sync_i(sync_i), .clk_o(clk_o), .tick_o(tick_o), .cfg_pend_o(cfg_pend_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Model: period k of an epoch starting at t0 begins at t0 + floor(k*P / 2^FRAC_W)
    longint unsigned m_t;
    longint unsigned m_t0   [N_CH];
    bit              m_run  [N_CH];
    logic [PW-1:0]   m_p    [N_CH];
    logic [PW-1:0]   m_s    [N_CH];
    bit              m_m    [N_CH];
    bit              m_sm   [N_CH];
    bit              m_pend [N_CH];
    logic [N_CH-1:0] exp_clk, exp_tick, exp_pend;

    function automatic longint unsigned pstart(longint unsigned k, logic [PW-1:0] p);
        return (k * longint'(p)) >> FRAC_W;
    endfunction

    task automatic phase(input int ch, output longint unsigned k,
                         output longint unsigned off, output longint unsigned len);
        longint unsigned d;
        d   = m_t - m_t0[ch];
        k   = (((d + 1) << FRAC_W) - 1) / longint'(m_p[ch]);
        off = d - pstart(k, m_p[ch]);
        len = pstart(k + 1, m_p[ch]) - pstart(k, m_p[ch]);
    endtask

    task automatic fresh(input int ch);
        if (m_pend[ch]) begin
            m_p[ch] = m_s[ch]; m_m[ch] = m_sm[ch]; m_pend[ch] = 0;
        end
        m_run[ch] = (m_p[ch][PW-1:FRAC_W] >= 2);
        m_t0[ch]  = m_t;
    endtask

    task automatic model_edge();
        longint unsigned k, off, len;
        if (rst_i) begin
            for (int c = 0; c < N_CH; c++) begin
                m_run[c] = 0; m_p[c] = '0; m_s[c] = '0;
                m_m[c] = 0; m_sm[c] = 0; m_pend[c] = 0; m_t0[c] = 0;
            end
            exp_clk = '0; exp_tick = '0; exp_pend = '0;
        end else if (cke_i) begin
            m_t++;
            for (int c = 0; c < N_CH; c++) begin
                if (!en_i[c]) m_run[c] = 0;
                else if (sync_i || !m_run[c]) fresh(c);
                else begin
                    phase(c, k, off, len);
                    if (off == 0 && k >= 1 && m_pend[c]) fresh(c);
                end
                if (cfg_wen_i && int'(cfg_ch_i) == c) begin
                    if (!m_run[c]) begin
                        m_p[c] = cfg_period_i; m_m[c] = cfg_mode_i;
                    end else begin
                        m_s[c] = cfg_period_i; m_sm[c] = cfg_mode_i; m_pend[c] = 1;
                    end
                end
                exp_clk[c] = 0; exp_tick[c] = 0;
                if (m_run[c]) begin
                    phase(c, k, off, len);
                    exp_tick[c] = (off == 0);
                    exp_clk[c]  = m_m[c] ? (off == 0) : (off < len / 2);
                end
                exp_pend[c] = m_pend[c];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        chk("clk_o", clk_o, exp_clk);
        chk("tick_o", tick_o, exp_tick);
        chk("cfg_pend_o", cfg_pend_o, exp_pend);
        cfg_wen_i = 1'b0;
        sync_i    = 1'b0;
    endtask

    task automatic wr(input int ch, input logic [PW-1:0] p, input logic mode);
        cfg_wen_i    = 1'b1;
        cfg_ch_i     = CH_W'(ch);
        cfg_period_i = p;
        cfg_mode_i   = mode;
        step();
    endtask

    initial begin
        int ticks, highs, any;
        m_t = 0;
        rst_i = 1'b1; cke_i = 1'b1; cfg_wen_i = 1'b0; cfg_ch_i = '0;
        cfg_period_i = '0; cfg_mode_i = 1'b0; en_i = '0; sync_i = 1'b0;
        repeat (2) step();
        rst_i = 1'b0;
        step();

        // P = 2.5: periods alternate 2,3 -> 400 ticks and 400 high cycles in 1000 cycles
        wr(0, {16'd2, 16'h8000}, 1'b0);
        en_i[0] = 1'b1;
        ticks = 0; highs = 0;
        for (int n = 0; n < 1000; n++) begin
            step();
            ticks += int'(tick_o[0]);
            highs += int'(clk_o[0]);
        end
        chk_int("ticks_p2p5", ticks, 400);
        chk_int("high_p2p5", highs, 400);

        // Running P = 10 on ch1, rewrite to 4 at cnt = 3
        wr(1, {16'd10, 16'h0}, 1'b0);
        en_i[1] = 1'b1;
        repeat (4) step();
        wr(1, {16'd4, 16'h0}, 1'b0);
        chk_int("pend_ch1", int'(cfg_pend_o[1]), 1);
        repeat (30) step();

        // Two channels out of phase, then a sync strobe aligns them
        wr(0, {16'd6, 16'h0}, 1'b0);
        wr(2, {16'd9, 16'h0}, 1'b0);
        en_i[2] = 1'b1;
        repeat (7) step();
        sync_i = 1'b1;
        step();
        chk_int("sync_ticks", int'({tick_o[0], tick_o[2]}), 3);
        repeat (40) step();

        // P = 5 in pulse mode, then back to 50 % duty
        wr(1, {16'd5, 16'h0}, 1'b1);
        sync_i = 1'b1;
        step();
        repeat (20) step();
        wr(1, {16'd5, 16'h0}, 1'b0);
        repeat (20) step();

        // P_int = 1 never runs; a valid write then starts the channel
        en_i[2] = 1'b0;
        step();
        wr(2, {16'd1, 16'hffff}, 1'b0);
        en_i[2] = 1'b1;
        any = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            any += int'(clk_o[2] | tick_o[2]);
        end
        chk_int("pint1_silent", any, 0);
        wr(2, {16'd3, 16'h0}, 1'b0);
        repeat (10) step();

        // Channel select beyond N_CH is ignored
        wr(3, {16'd7, 16'h0}, 1'b0);
        repeat (5) step();

        // Randomized traffic including clock-enable gaps and occasional reset
        for (int n = 0; n < 3000; n++) begin
            cke_i = ($urandom_range(0, 9) != 0);
            rst_i = ($urandom_range(0, 499) == 0);
            sync_i = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0) en_i[$urandom_range(0, N_CH - 1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                cfg_wen_i    = 1'b1;
                cfg_ch_i     = CH_W'($urandom_range(0, 3));
                cfg_period_i = {16'($urandom_range(0, 9)),
                                ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom)};
                cfg_mode_i   = 1'($urandom_range(0, 1));
            end
            step();
        end
        rst_i = 1'b0; cke_i = 1'b1;

        // Reset mid-period with every channel running, then re-enable with P = 0
        en_i = '1;
        for (int c = 0; c < N_CH; c++) wr(c, {16'd7, 16'h4000}, 1'b0);
        sync_i = 1'b1;
        step();
        repeat (3) step();
        rst_i = 1'b1;
        step();
        chk_int("rst_outputs", int'({clk_o, tick_o, cfg_pend_o}), 0);
        rst_i = 1'b0;
        any = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            any += int'(|{clk_o, tick_o});
        end
        chk_int("p0_silent", any, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
